fpalu_op_sequencer: RTL and testbench

//   Issue side of the FPALU operand/selector interface. Accepts (a, b, op) requests on a valid/ready handshake
//   and drives alu_a/alu_b/alu_sel to the combinational FPALU, holding them stable for a settle window.

---
 rtl/fpalu_pkg.sv | 14 +
 rtl/fpalu_op_sequencer.sv | 95 +++++++++
 tb/tb_fpalu_op_sequencer.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/fpalu_pkg.sv
// fpalu_pkg: shared widths, selector codes and sequencer state encoding for the FPALU front end
package fpalu_pkg;
  localparam int WIDTH = 32;
  localparam int SEL_W = 3;
  localparam int NUM_OPS = 5;
  localparam int SETTLE_CYCLES = 2;
  localparam int CNT_W = 16;
  localparam logic [SEL_W-1:0] SEL_ADD = 3'd0;
  localparam logic [SEL_W-1:0] SEL_SUB = 3'd1;
  localparam logic [SEL_W-1:0] SEL_MUL = 3'd2;
  localparam logic [SEL_W-1:0] SEL_DIV = 3'd3;
  localparam logic [SEL_W-1:0] SEL_CMP = 3'd4;
  typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;
endpackage

// File: rtl/fpalu_op_sequencer.sv
// fpalu_op_sequencer: handshaked issue/capture front end for the combinational FPALU
module fpalu_op_sequencer #(
  parameter int WIDTH = fpalu_pkg::WIDTH,
  parameter int SEL_W = fpalu_pkg::SEL_W,
  parameter int NUM_OPS = fpalu_pkg::NUM_OPS,
  parameter int SETTLE_CYCLES = fpalu_pkg::SETTLE_CYCLES,
  parameter int CNT_W = fpalu_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [SEL_W-1:0] req_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [SEL_W-1:0] alu_sel,
  input  logic [WIDTH-1:0] alu_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_err,
  output logic             busy,
  output logic [CNT_W-1:0] op_count,
  output logic [CNT_W-1:0] err_count
);
  import fpalu_pkg::*;
  localparam int CW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
  state_t state;
  logic [CW-1:0] cnt;
  logic accept, legal, settled;
  assign accept = req_valid && req_ready;
  assign legal = int'(req_op) < NUM_OPS;
  assign settled = cnt == CW'(SETTLE_CYCLES - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      req_ready <= 1'b1;
      busy <= 1'b0;
      rsp_valid <= 1'b0;
      op_count <= '0;
      err_count <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          state <= legal ? SETTLE : RESP;
          cnt <= '0;
          req_ready <= 1'b0;
          busy <= 1'b1;
          rsp_valid <= !legal;
        end
        SETTLE: begin
          cnt <= cnt + 1'b1;
          if (settled) begin
            state <= RESP;
            rsp_valid <= 1'b1;
          end
        end
        RESP: if (rsp_ready) begin
          state <= IDLE;
          req_ready <= 1'b1;
          busy <= 1'b0;
          rsp_valid <= 1'b0;
          if (rsp_err) err_count <= err_count + 1'b1;
          else op_count <= op_count + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
  // Illegal selectors never touch alu_*, so the FPALU inputs keep the last legal operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a <= '0;
      alu_b <= '0;
      alu_sel <= '0;
      rsp_result <= '0;
      rsp_err <= 1'b0;
    end else if (state == IDLE && accept) begin
      if (legal) begin
        alu_a <= req_a;
        alu_b <= req_b;
        alu_sel <= req_op;
      end else begin
        rsp_result <= '0;
        rsp_err <= 1'b1;
      end
    end else if (state == SETTLE && settled) begin
      rsp_result <= alu_out;
      rsp_err <= 1'b0;
    end
  end
endmodule

// File: tb/tb_fpalu_op_sequencer.sv
// tb_fpalu_op_sequencer: directed bench with a countdown model of the sequencer checked every cycle
module tb_fpalu_op_sequencer;
  import fpalu_pkg::*;
  logic clk = 0, rst_n = 0, req_valid = 0, rsp_ready = 0;
  logic [31:0] req_a = 0, req_b = 0, alu_a, alu_b, alu_out, rsp_result;
  logic [2:0] req_op = 0, alu_sel;
  logic req_ready, rsp_valid, rsp_err, busy;
  logic [15:0] op_count, err_count;
  fpalu_op_sequencer dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_err(rsp_err),
    .busy(busy), .op_count(op_count), .err_count(err_count)
  );
  assign alu_out = alu_a ^ alu_b;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int checks = 0, passes = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask
  // Model: phase 0 idle, 1 counting down the settle window, 2 holding a response.
  int m_ph, m_left;
  logic [31:0] m_a, m_b, m_res;
  logic [2:0] m_sel;
  logic m_err;
  logic [15:0] m_ops, m_errs;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph <= 0; m_left <= 0; m_a <= 0; m_b <= 0; m_sel <= 0;
      m_res <= 0; m_err <= 0; m_ops <= 0; m_errs <= 0;
    end else if (m_ph == 0) begin
      if (req_valid) begin
        if (int'(req_op) < NUM_OPS) begin
          m_a <= req_a; m_b <= req_b; m_sel <= req_op; m_left <= SETTLE_CYCLES; m_ph <= 1;
        end else begin
          m_res <= 0; m_err <= 1; m_ph <= 2;
        end
      end
    end else if (m_ph == 1) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_res <= m_a ^ m_b; m_err <= 0; m_ph <= 2;
      end
    end else if (rsp_ready) begin
      m_ph <= 0;
      if (m_err) m_errs <= m_errs + 1;
      else m_ops <= m_ops + 1;
    end
  end
  always @(negedge clk) begin
    chk("req_ready", req_ready, m_ph == 0);
    chk("busy", busy, m_ph != 0);
    chk("rsp_valid", rsp_valid, m_ph == 2);
    chk("alu_a", alu_a, m_a);
    chk("alu_b", alu_b, m_b);
    chk("alu_sel", alu_sel, m_sel);
    chk("op_count", op_count, m_ops);
    chk("err_count", err_count, m_errs);
    if (m_ph == 2) begin
      chk("rsp_result", rsp_result, m_res);
      chk("rsp_err", rsp_err, m_err);
    end
  end
  logic prev_v = 0;
  int rise_q[$];
  logic [31:0] res_q[$];
  always @(negedge clk) begin
    if (rsp_valid && !prev_v) begin
      rise_q.push_back(cyc);
      res_q.push_back(rsp_result);
    end
    prev_v <= rsp_valid;
  end
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op, output int acc);
    int n = 0;
    @(negedge clk);
    req_a = a; req_b = b; req_op = op; req_valid = 1;
    while (!req_ready && n < 40) begin @(negedge clk); n++; end
    chk("accept_ready", req_ready, 1);
    @(posedge clk);
    @(negedge clk);
    acc = cyc;
    req_valid = 0; req_a = $urandom; req_b = $urandom; req_op = 3'($urandom);
  endtask
  task automatic wait_rsp(output int t);
    int n = 0;
    while (!rsp_valid && n < 40) begin @(negedge clk); n++; end
    chk("rsp_seen", rsp_valid, 1);
    t = cyc;
  endtask
  initial begin
    int acc, t, base, n;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_op_count", op_count, 0);
    #2 rst_n = 1;
    rsp_ready = 1;
    send(32'h41200000, 32'h3F800000, SEL_SUB, acc);
    chk("t2_alu_sel", alu_sel, 1);
    wait_rsp(t);
    chk("t2_latency", t - acc, 2);
    chk("t2_result", rsp_result, 32'h7EA00000);
    @(negedge clk);
    chk("t2_op_count", op_count, 1);
    rsp_ready = 0;
    send(32'd1, 32'd2, SEL_ADD, acc);
    wait_rsp(t);
    repeat (5) begin
      @(negedge clk);
      chk("t3_hold_valid", rsp_valid, 1);
      chk("t3_hold_result", rsp_result, 3);
      chk("t3_req_ready", req_ready, 0);
    end
    rsp_ready = 1;
    @(negedge clk);
    chk("t3_idle", req_ready, 1);
    chk("t3_op_count", op_count, 2);
    send(32'hDEAD, 32'hBEEF, 3'd6, acc);
    chk("t4_valid", rsp_valid, 1);
    chk("t4_err", rsp_err, 1);
    chk("t4_result", rsp_result, 0);
    chk("t4_alu_a", alu_a, 1);
    chk("t4_alu_b", alu_b, 2);
    @(negedge clk);
    chk("t4_err_count", err_count, 1);
    base = rise_q.size();
    for (int i = 0; i < 5; i++) send(32'd10, 32'd1, 3'(i), acc);
    n = 0;
    while (rise_q.size() < base + 5 && n < 40) begin @(negedge clk); n++; end
    chk("t5_count", rise_q.size() - base, 5);
    for (int i = 0; i < 5; i++)
      if (base + i < rise_q.size()) begin
        chk("t5_result", res_q[base+i], 32'h0000000B);
        if (i > 0) chk("t5_spacing", rise_q[base+i] - rise_q[base+i-1], 4);
      end
    @(negedge clk);
    chk("t5_op_count", op_count, 7);
    send(32'd5, 32'd3, SEL_MUL, acc);
    #2 rst_n = 0;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_rsp_valid", rsp_valid, 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1;
    repeat (4) begin
      @(negedge clk);
      chk("t6_no_pulse", rsp_valid, 0);
    end
    chk("t6_op_count", op_count, 0);
    send(32'd5, 32'd3, SEL_MUL, acc);
    wait_rsp(t);
    chk("t6_latency", t - acc, 2);
    chk("t6_result", rsp_result, 6);
    @(negedge clk);
    chk("t6_op_count_after", op_count, 1);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
